// File: rtl/smachine_pkg.sv
// Shared types and constants for the S-Machine sequencer.
// Opcode fields, FSM state encoding and data-memory mux select.
package smachine_pkg;

    localparam logic [3:0] OP_LD    = 4'b0000;
    localparam logic [3:0] OP_ST    = 4'b0001;
    localparam logic [3:0] OP_BR    = 4'b0011;
    localparam logic       RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MWAIT,
        BOUND,
        HOST
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CPU,
        SEL_HOST
    } mem_sel_e;

    // LD with inst[10]=1 is an immediate load and never touches data memory.
    function automatic logic is_mem_op(input logic [15:0] i);
        return ((i[15:12] == OP_LD) && !i[10]) || (i[15:12] == OP_ST);
    endfunction

    function automatic logic is_halt(input logic [15:0] i, input logic [7:0] pc);
        return (i[15:12] == OP_BR) && ((i[11:8] == 4'h0) || (i[11:8] == 4'hF)) &&
               (i[7:0] == pc);
    endfunction

endpackage

// File: rtl/smachine_sequencer_if.sv
// Host (loader/debug) access port into the sequencer's data-memory arbiter.
// Host holds req until done; done is a single-cycle completion pulse.
interface smachine_sequencer_if;
    logic        host_req;
    logic        host_rw;
    logic [8:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt;
    logic        host_done;
    logic [15:0] host_rdata;

    modport master (
        output host_req, host_rw, host_addr, host_wdata,
        input  host_gnt, host_done, host_rdata
    );

    modport slave (
        input  host_req, host_rw, host_addr, host_wdata,
        output host_gnt, host_done, host_rdata
    );
endinterface

// File: rtl/smachine_dmem_arb.sv
// CPU/host data-memory mux with held address/data and host read-data capture.
// Mux is combinational; host_rdata updates one cycle after a capture cycle.
module smachine_dmem_arb
    import smachine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  mem_sel_e    sel,
    input  logic        capture,
    input  logic        cpu_rw,
    input  logic [8:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        host_rw,
    input  logic [8:0]  host_addr,
    input  logic [15:0] host_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_rw,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] host_rdata
);

    logic [8:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] host_rdata_q, host_rdata_d;

    // With no owner the bus is forced to read and parks on its last address.
    always_comb begin
        mem_rw    = ~RW_WRITE;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        unique case (sel)
            SEL_CPU: begin
                mem_rw    = cpu_rw;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            SEL_HOST: begin
                mem_rw    = host_rw;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            default: ;
        endcase
        addr_d       = mem_addr;
        wdata_d      = mem_wdata;
        host_rdata_d = capture ? mem_rdata : host_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            host_rdata_q <= '0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign host_rdata = host_rdata_q;

endmodule

// File: rtl/smachine_sequencer.sv
// Fetch/execute controller: ROM fetch, one-cycle CPU enable, LD/ST wait states, host arbitration.
// Instruction period is IMEM_LAT+3 cycles (+MEM_WAIT for LD/ST); host waits for an instruction boundary.
module smachine_sequencer
    import smachine_pkg::*;
#(
    parameter int IMEM_LAT  = 1,
    parameter int MEM_WAIT  = 1,
    parameter bit HOST_FAIR = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       step,
    input  logic [7:0]                 pc,
    output logic [7:0]                 imem_addr,
    input  logic [15:0]                imem_data,
    output logic [15:0]                inst,
    output logic                       cpu_enable,
    input  logic                       cpu_rw,
    input  logic [8:0]                 cpu_addr,
    input  logic [15:0]                cpu_wdata,
    smachine_sequencer_if.slave        hbus,
    output logic                       mem_rw,
    output logic [8:0]                 mem_addr,
    output logic [15:0]                mem_wdata,
    input  logic [15:0]                mem_rdata,
    output logic                       halted
);

    localparam int              CNT_W      = 8;
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(IMEM_LAT);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MEM_WAIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      inst_q, inst_d;
    logic             halted_q, halted_d;
    logic             last_host_q, last_host_d;
    logic             host_done_q, host_done_d;
    mem_sel_e         sel;
    logic             host_gnt;
    logic             host_req_ok;

    // The host still holds req in the cycle it sees done; that cycle must not re-grant.
    assign host_req_ok = hbus.host_req & ~host_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        inst_d      = inst_q;
        halted_d    = halted_q;
        last_host_d = last_host_q;
        host_done_d = 1'b0;
        sel         = SEL_NONE;
        cpu_enable  = 1'b0;
        host_gnt    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host_req_ok) begin
                    state_d = HOST;
                end else if ((run && !halted_q) || step) begin
                    state_d  = FETCH;
                    cnt_d    = '0;
                    halted_d = halted_q & ~step;
                end
            end
            FETCH: begin
                // One address cycle plus IMEM_LAT cycles for a registered ROM.
                if (cnt_q == FETCH_LAST) begin
                    inst_d  = imem_data;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                cpu_enable  = 1'b1;
                sel         = SEL_CPU;
                last_host_d = 1'b0;
                if (is_halt(inst_q, pc)) begin
                    halted_d = 1'b1;
                end
                if (is_mem_op(inst_q)) begin
                    state_d = MWAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = BOUND;
                end
            end
            MWAIT: begin
                sel = SEL_CPU;
                if (cnt_q >= WAIT_LAST) begin
                    state_d = BOUND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BOUND: begin
                if (host_req_ok && !(HOST_FAIR && last_host_q && run)) begin
                    state_d = HOST;
                end else if (run && !halted_q) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            HOST: begin
                host_gnt    = 1'b1;
                sel         = SEL_HOST;
                host_done_d = 1'b1;
                last_host_d = 1'b1;
                state_d     = BOUND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            inst_q      <= '0;
            halted_q    <= 1'b0;
            last_host_q <= 1'b0;
            host_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inst_q      <= inst_d;
            halted_q    <= halted_d;
            last_host_q <= last_host_d;
            host_done_q <= host_done_d;
        end
    end

    smachine_dmem_arb u_arb (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .capture    (host_gnt),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .host_rw    (hbus.host_rw),
        .host_addr  (hbus.host_addr),
        .host_wdata (hbus.host_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .host_rdata (hbus.host_rdata)
    );

    assign imem_addr      = pc;
    assign inst           = inst_q;
    assign halted         = halted_q;
    assign hbus.host_gnt  = host_gnt;
    assign hbus.host_done = host_done_q;

endmodule
